// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: walks the lanes of a vector load or store in order
// over a single-element memory port using a req/ack handshake. It keeps the
// pipeline stalled while the walk runs, then pulses done for one cycle.

// One lane of the assembled load result. It is written when that lane's
// read element is acked, and holds its value otherwise.
module vms_lane #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);
   logic [DATA_WIDTH-1:0] r_q;

   // lane storage; reset clears partially loaded data
   always_ff @(posedge i_clk) begin
      if (i_reset)   r_q <= '0;
      else if (i_we) r_q <= i_d;
   end

   assign o_q = r_q;
endmodule

module vector_mem_sequencer #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_startM,
   input  logic                        i_isStoreM,
   input  logic [ADDR_WIDTH-1:0]       i_baseAddrM,
   input  logic [LANES*DATA_WIDTH-1:0] i_storeVectorM,
   output logic                        o_memReq,
   output logic                        o_memWe,
   output logic [ADDR_WIDTH-1:0]       o_memAddr,
   output logic [DATA_WIDTH-1:0]       o_memWdata,
   input  logic                        i_memAck,
   input  logic [DATA_WIDTH-1:0]       i_memRdata,
   output logic                        o_stallOut,
   output logic                        o_doneOut,
   output logic [LANES*DATA_WIDTH-1:0] o_loadVectorOut
);
   localparam int LW = $clog2(LANES);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // request as captured from the memory stage
   typedef struct packed {
      logic                                 is_store;
      logic [ADDR_WIDTH-1:0]                base;
      logic [LANES-1:0][DATA_WIDTH-1:0]     data;
   } req_t;

   state_t          r_state;
   state_t          w_next;
   req_t            r_req;
   logic [LW-1:0]   r_lane;
   logic            w_last;
   logic            w_start;
   logic            w_ack;
   logic [LANES-1:0] w_lane_we;

   assign w_start = (r_state == S_IDLE) & i_startM;
   assign w_ack   = (r_state == S_BUSY) & i_memAck;
   assign w_last  = (r_lane == LW'(LANES-1));

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // request capture and lane counter; a held startM outside IDLE is ignored
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_req  <= '0;
         r_lane <= '0;
      end else if (w_start) begin
         r_req.is_store <= i_isStoreM;
         r_req.base     <= i_baseAddrM;
         r_req.data     <= i_storeVectorM;
         r_lane         <= '0;
      end else if (w_ack && !w_last) begin
         r_lane <= r_lane + 1'b1;
      end
   end

   // next state and handshake outputs
   always_comb begin
      w_next     = r_state;
      o_memReq   = 1'b0;
      o_memWe    = 1'b0;
      o_memAddr  = '0;
      o_memWdata = '0;
      o_doneOut  = 1'b0;
      o_stallOut = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_stallOut = i_startM;
            if (i_startM) w_next = S_BUSY;
         end
         S_BUSY: begin
            o_stallOut = 1'b1;
            o_memReq   = 1'b1;
            o_memWe    = r_req.is_store;
            // address wraps modulo 2^ADDR_WIDTH by natural truncation
            o_memAddr  = r_req.base + ADDR_WIDTH'(r_lane);
            o_memWdata = r_req.data[r_lane];
            if (i_memAck && w_last) w_next = S_DONE;
         end
         S_DONE: begin
            o_doneOut = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // one storage element per lane, written only by its own read ack
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_we[g] = w_ack & ~r_req.is_store & (r_lane == LW'(g));
      vms_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_we    (w_lane_we[g]),
         .i_d     (i_memRdata),
         .o_q     (o_loadVectorOut[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer: directed cases plus randomized loads and
// stores with random ack stalls, compared against a lane-walk reference model.
module tb_vector_mem_sequencer;
   localparam int L  = 4;
   localparam int DW = 8;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            reset, startM, isStoreM, memAck;
   logic [AW-1:0]   baseAddrM;
   logic [L*DW-1:0] storeVectorM;
   logic [DW-1:0]   memRdata;
   logic            memReq, memWe, stallOut, doneOut;
   logic [AW-1:0]   memAddr;
   logic [DW-1:0]   memWdata;
   logic [L*DW-1:0] loadVectorOut;

   int checks = 0;
   int errors = 0;
   logic [L*DW-1:0] exp_lv;

   vector_mem_sequencer #(.LANES(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk(clk), .i_reset(reset), .i_startM(startM), .i_isStoreM(isStoreM),
      .i_baseAddrM(baseAddrM), .i_storeVectorM(storeVectorM),
      .o_memReq(memReq), .o_memWe(memWe), .o_memAddr(memAddr), .o_memWdata(memWdata),
      .i_memAck(memAck), .i_memRdata(memRdata),
      .o_stallOut(stallOut), .o_doneOut(doneOut), .o_loadVectorOut(loadVectorOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // idle cycles with stray acks; nothing may move
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startM = 1'b0;
         memAck = 1'($urandom_range(0, 1));
         memRdata = DW'($urandom);
         #1;
         chk("idle_req", memReq, 1'b0);
         chk("idle_stall", stallOut, 1'b0);
         chk("idle_done", doneOut, 1'b0);
         chk("idle_lv", loadVectorOut, exp_lv);
      end
      @(negedge clk);
      memAck = 1'b0;
   endtask

   // One vector access. waits[i] = number of ack-low cycles before lane i is
   // acked. abort_lane >= 0 asserts reset right after that lane's ack.
   task automatic run_txn(input bit st, input logic [AW-1:0] base,
                          input logic [L*DW-1:0] vec, input logic [L-1:0][3:0] waits,
                          input bit hold, input bit fixed_rd, input int abort_lane);
      logic [AW-1:0] addr;
      logic [DW-1:0] rd;
      int cycles = 0;
      int expect_lat = L + 1;
      for (int i = 0; i < L; i++) expect_lat += int'(waits[i]);

      @(negedge clk);
      startM = 1'b1; isStoreM = st; baseAddrM = base; storeVectorM = vec; memAck = 1'b0;
      #1;
      chk("c0_stall", stallOut, 1'b1);
      chk("c0_req", memReq, 1'b0);
      @(posedge clk); cycles++;
      #1;
      if (!hold) begin
         // captured copies must be used from here on
         startM = 1'b0; isStoreM = ~st; baseAddrM = $urandom; storeVectorM = $urandom;
      end
      for (int ln = 0; ln < L; ln++) begin
         for (int w = 0; w <= int'(waits[ln]); w++) begin
            @(negedge clk);
            addr = base + AW'(ln);
            chk("req", memReq, 1'b1);
            chk("we", memWe, st);
            chk("addr", memAddr, addr);
            if (st) chk("wdata", memWdata, vec[ln*DW +: DW]);
            chk("stall", stallOut, 1'b1);
            chk("done_early", doneOut, 1'b0);
            chk("lv_partial", loadVectorOut, exp_lv);
            rd = fixed_rd ? (8'hA0 + DW'(addr[3:0])) : DW'($urandom);
            memAck = (w == int'(waits[ln]));
            memRdata = rd;
            @(posedge clk); cycles++;
            #1;
            if (memAck && !st) exp_lv[ln*DW +: DW] = rd;
            memAck = 1'b0;
         end
         if (ln == abort_lane) begin
            @(negedge clk);
            startM = 1'b0; reset = 1'b1; memAck = 1'b1; memRdata = DW'($urandom);
            @(posedge clk);
            #1;
            reset = 1'b0; memAck = 1'b0;
            exp_lv = '0;
            @(negedge clk);
            chk("rst_req", memReq, 1'b0);
            chk("rst_stall", stallOut, 1'b0);
            chk("rst_done", doneOut, 1'b0);
            chk("rst_lv", loadVectorOut, exp_lv);
            return;
         end
      end
      @(negedge clk);
      chk("done", doneOut, 1'b1);
      chk("done_stall", stallOut, 1'b0);
      chk("done_req", memReq, 1'b0);
      chk("done_lv", loadVectorOut, exp_lv);
      chk("latency", 32'(cycles), 32'(expect_lat));
      @(posedge clk);
      #1 startM = 1'b0;
      @(negedge clk);
      chk("post_done", doneOut, 1'b0);
      chk("post_req", memReq, 1'b0);
      chk("post_stall", stallOut, 1'b0);
   endtask

   initial begin
      logic [L-1:0][3:0] wz;
      logic [L-1:0][3:0] wr;
      wz = '0;
      reset = 1'b1; startM = 1'b0; isStoreM = 1'b0; memAck = 1'b0;
      baseAddrM = '0; storeVectorM = '0; memRdata = '0; exp_lv = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_memReq", memReq, 1'b0);
      chk("rst_memWe", memWe, 1'b0);
      chk("rst_memAddr", memAddr, '0);
      chk("rst_memWdata", memWdata, '0);
      chk("rst_doneOut", doneOut, 1'b0);
      chk("rst_stallOut", stallOut, 1'b0);
      chk("rst_lv", loadVectorOut, '0);

      // store, ack tied high
      run_txn(1'b1, 32'h100, 32'h44332211, wz, 1'b0, 1'b0, -1);
      idle_cycles(3);
      // load, ack tied high, memory returns A0+addr[3:0]
      run_txn(1'b0, 32'h8, '0, wz, 1'b0, 1'b1, -1);
      chk("load_vec", loadVectorOut, 32'hABAAA9A8);
      // load with two ack-low cycles on lane 1
      wr = '0; wr[1] = 4'd2;
      run_txn(1'b0, 32'h20, '0, wr, 1'b0, 1'b0, -1);
      // address wrap
      run_txn(1'b0, 32'hFFFF_FFFE, '0, wz, 1'b0, 1'b1, -1);
      chk("wrap_vec", loadVectorOut, 32'hA1A0AFAE);
      // startM held high through the whole access
      run_txn(1'b1, 32'h40, 32'hDEADBEEF, wz, 1'b1, 1'b0, -1);
      idle_cycles(2);
      // reset after lane 2 of a load, then a normal access
      run_txn(1'b0, 32'h200, '0, wz, 1'b0, 1'b0, 2);
      run_txn(1'b0, 32'h8, '0, wz, 1'b0, 1'b1, -1);
      chk("after_rst_vec", loadVectorOut, 32'hABAAA9A8);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < L; i++) wr[i] = 4'($urandom_range(0, 3));
         run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, wr,
                 1'($urandom_range(0, 1)), 1'b0, -1);
         idle_cycles($urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end
endmodule
